// File: rtl/pfetch_pkg.sv
// Shared types and default sizing for the prefetch unit.
package pfetch_pkg;

  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned IW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic {
    S_VEC = 1'b0,
    S_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/pfetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with synchronous clear.
module pfetch_fifo
  import pfetch_pkg::*;
#(
  parameter int unsigned W     = AW_DEF + IW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  logic [W-1:0]                 i_wdata,
  output logic [W-1:0]                 o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Empty queue reads as zero so the head is defined straight after reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pfetch_unit.sv
// Instruction prefetch: vector load, PC sequencing, redirect handling, queue to decode.
// Optional same-cycle empty-queue bypass to decode: define PFETCH_BYPASS_EN.
module pfetch_unit
  import pfetch_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned IW    = IW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_f,
  input  logic                         redirect_valid,
  input  logic [AW-1:0]                redirect_pc,
  output logic [AW-1:0]                imem_addr,
  input  logic [IW-1:0]                imem_rdata,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [IW-1:0]                dec_instr,
  output logic [AW-1:0]                dec_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  state_t           r_state;
  logic [AW-1:0]    r_pc;
  logic             w_run;
  logic             w_redir;
  logic             w_pop;
  logic             w_fetch;
  logic             w_push;
  logic             w_empty;
  logic             w_full;
  logic [AW+IW-1:0] w_head;

  assign w_run     = (r_state == S_RUN);
  assign w_redir   = w_run & redirect_valid;
  assign w_pop     = w_run & ~w_redir & ~w_empty & dec_ready;
  assign w_fetch   = w_run & ~w_redir & ~stall_f & (~w_full | w_pop);
  assign imem_addr = w_run ? r_pc : '0;

`ifdef PFETCH_BYPASS_EN
  logic r_redir_d;
  logic w_bypass;

  // Bypass is held off the cycle after a redirect so decode sees one idle cycle.
  assign w_bypass  = w_fetch & w_empty & ~r_redir_d;
  assign w_push    = w_fetch & ~(w_bypass & dec_ready);
  assign dec_valid = ~w_empty | w_bypass;
  assign dec_instr = w_bypass ? imem_rdata : w_head[AW+IW-1:AW];
  assign dec_pc    = w_bypass ? r_pc : w_head[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redir_d <= 1'b0;
    end else begin
      r_redir_d <= w_redir;
    end
  end
`else
  assign w_push    = w_fetch;
  assign dec_valid = ~w_empty;
  assign dec_instr = w_head[AW+IW-1:AW];
  assign dec_pc    = w_head[AW-1:0];
`endif

  pfetch_fifo #(
    .W     (AW + IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_redir),
    .i_wdata ({imem_rdata, r_pc}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_VEC;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_VEC: begin
          r_pc    <= AW'(imem_rdata);
          r_state <= S_RUN;
        end
        default: begin
          if (w_redir) begin
            r_pc <= redirect_pc;
          end else if (w_fetch) begin
            r_pc <= r_pc + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pfetch_unit.sv
// Self-checking bench for pfetch_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_pfetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 8;
  localparam int unsigned DEPTH = 4;
`ifdef PFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          stall_f;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          dec_valid;
  logic          dec_ready;
  logic [IW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;
  logic [2:0]    occupancy;

  logic [7:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pfetch_unit #(
    .AW    (AW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .occupancy      (occupancy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {instr, pc} plus the fetch PC.
  typedef struct {
    logic [7:0] instr;
    logic [7:0] pc;
  } ent_t;

  ent_t       q[$];
  bit         m_ok = 1'b0;
  bit         m_vec;
  bit         m_redir_prev;
  logic [7:0] m_pc;

  always @(negedge clk) begin : model
    int unsigned sz;
    bit          m_pop;
    bit          m_fetch;
    bit          m_byp;
    bit          e_valid;
    sz      = q.size();
    m_pop   = !m_vec && !redirect_valid && sz != 0 && dec_ready;
    m_fetch = !m_vec && !redirect_valid && !stall_f && (sz < DEPTH || m_pop);
    m_byp   = BYP && m_fetch && sz == 0 && !m_redir_prev;
    e_valid = (sz != 0) || m_byp;
    if (m_ok) begin
      chk("m_addr", imem_addr, m_vec ? 8'h00 : m_pc);
      chk("m_occ", occupancy, sz);
      chk("m_valid", dec_valid, e_valid);
      if (e_valid) begin
        chk("m_pc", dec_pc, (sz != 0) ? q[0].pc : m_pc);
        chk("m_instr", dec_instr, (sz != 0) ? q[0].instr : mem[m_pc]);
      end
    end
    if (reset) begin
      m_ok = 1'b1;
      m_vec = 1'b1;
      m_pc = 8'h00;
      m_redir_prev = 1'b0;
      q.delete();
    end else if (m_ok) begin
      if (m_vec) begin
        m_pc = mem[0];
        m_vec = 1'b0;
        m_redir_prev = 1'b0;
      end else if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc;
        m_redir_prev = 1'b1;
      end else begin
        m_redir_prev = 1'b0;
        if (m_pop) void'(q.pop_front());
        if (m_fetch) begin
          if (!(m_byp && dec_ready)) q.push_back('{instr: mem[m_pc], pc: m_pc});
          m_pc = m_pc + 8'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20;
    reset = 1'b1;
    stall_f = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    step();
    step();
    #1;
    chk("rst_valid", dec_valid, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", dec_instr, 0);
    chk("rst_pc", dec_pc, 0);
    chk("rst_occ", occupancy, 0);
    reset = 1'b0;
    #1 chk("vec_addr", imem_addr, 8'h00);

    // Fill with decode blocked: six run cycles
    step();
    #1 chk("run_addr", imem_addr, 8'h20);
`ifdef PFETCH_BYPASS_EN
    chk("first_valid", dec_valid, 1);
`else
    chk("first_valid", dec_valid, 0);
`endif
    for (int i = 0; i < 5; i++) step();
    #1;
    chk("fill_occ", occupancy, 4);
    chk("fill_addr", imem_addr, 8'h24);
    step();
    #1 chk("fill_hold", imem_addr, 8'h24);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_pc", dec_pc, 8'h20 + i);
      step();
    end
    // One pop without push to leave three entries
    stall_f = 1'b1;
    step();
    stall_f = 1'b0;
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    #1 chk("pre_redir_occ", occupancy, 3);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("redir_occ", occupancy, 0);
    chk("redir_valid", dec_valid, 0);
    step();
    #1;
    chk("redir_head_valid", dec_valid, 1);
    chk("redir_head_pc", dec_pc, 8'h80);
    chk("redir_head_instr", dec_instr, mem[8'h80]);

    // Redirect beats stall, then stall holds PC
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    stall_f = 1'b1;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_addr", imem_addr, 8'h40);
      chk("stall_occ", occupancy, 0);
      step();
    end
    stall_f = 1'b0;

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    step();
    dec_ready = 1'b1;
    #1 chk("wrap_occ", occupancy, 3);
    chk("wrap_pc0", dec_pc, 8'hFF);
    step();
    #1 chk("wrap_pc1", dec_pc, 8'h00);
    step();
    #1 chk("wrap_pc2", dec_pc, 8'h01);

    // Fetch into an empty queue with decode ready
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    stall_f = 1'b1;
    step();
    stall_f = 1'b0;
    #1;
`ifdef PFETCH_BYPASS_EN
    chk("byp_valid", dec_valid, 1);
    chk("byp_pc", dec_pc, 8'h10);
    step();
    #1 chk("byp_occ", occupancy, 0);
`else
    chk("nobyp_valid", dec_valid, 0);
    step();
    #1;
    chk("nobyp_valid_late", dec_valid, 1);
    chk("nobyp_pc", dec_pc, 8'h10);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      reset = ($urandom_range(199) == 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc = 8'($urandom);
      stall_f = ($urandom_range(3) == 0);
      dec_ready = $urandom_range(1) == 1;
    end
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pfetch_unit.md
PFETCH_UNIT -- requirements
Module: pfetch_unit

Interface
REQ-001 Parameter AW, 8, PC and instruction-memory address width in bits.
REQ-002 Parameter IW, 8, instruction word width in bits.
REQ-003 Parameter DEPTH, 4, prefetch queue entries; power of two, at least 2.
REQ-004 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port stall_f, input, 1, freezes fetching: no push and PC held.
REQ-007 Port redirect_valid, input, 1, control-flow change (jump, call, ret, loop, interrupt).
REQ-008 Port redirect_pc, input, AW, target PC when redirect_valid is high.
REQ-009 Port imem_addr, output, AW, instruction-memory address.
REQ-010 Port imem_rdata, input, IW, combinational read data for imem_addr in the same cycle.
REQ-011 Port dec_valid, output, 1, queue head is valid.
REQ-012 Port dec_ready, input, 1, decode accepts the head; a pop occurs when dec_valid and dec_ready are both high.
REQ-013 Port dec_instr, output, IW, head instruction.
REQ-014 Port dec_pc, output, AW, PC of the head instruction.
REQ-015 Port occupancy, output, $clog2(DEPTH+1), number of queued entries.

Function
REQ-016 The FSM SHALL have two states: S_VEC and S_RUN.
REQ-017 In S_VEC: imem_addr = 0, no push; the next cycle loads pc <= imem_rdata and moves to S_RUN.
REQ-018 In S_RUN: imem_addr = pc.
REQ-019 In S_RUN, a fetch SHALL occur when !stall_f, !redirect_valid, and (occupancy < DEPTH or a pop occurs this cycle).
REQ-020 A fetch SHALL push {imem_rdata, pc} and set pc <= pc + 1, wrapping modulo 2^AW (all-ones wraps to 0).
REQ-021 When no fetch occurs, pc SHALL hold.
REQ-022 redirect_valid in S_RUN SHALL clear the queue (occupancy becomes 0), set pc <= redirect_pc, suppress push and pop that cycle, and force dec_valid = 0 in the following cycle.
REQ-023 Priority: reset > redirect_valid > stall_f > fetch.
REQ-024 redirect_valid in S_VEC SHALL be ignored.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged, with FIFO order preserved.
REQ-026 With occupancy = DEPTH and no pop: no fetch and pc held. A pop must never occur with occupancy 0.
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap naturally.
REQ-028 dec_instr and dec_pc SHALL be stable while dec_valid is high and dec_ready is low.
REQ-029 Without the bypass, dec_valid = (occupancy != 0); minimum fetch-to-decode latency is 1 cycle.

Reset
REQ-030 While reset is high at a clock edge: state <= S_VEC, pc <= 0, pointers <= 0, occupancy <= 0.
REQ-031 The cycle after reset: dec_valid = 0, imem_addr = 0, dec_instr = 0, dec_pc = 0.
REQ-032 Reset mid-operation SHALL discard all queued entries and re-run the vector load.

Configuration
REQ-033 Macro PFETCH_BYPASS_EN, when defined: if occupancy = 0 and a fetch occurs, dec_valid = 1 combinationally with dec_instr = imem_rdata and dec_pc = pc.
REQ-034 With PFETCH_BYPASS_EN defined, if dec_ready is also high, that word SHALL be consumed without a push (occupancy stays 0); otherwise it is pushed.
REQ-035 Without PFETCH_BYPASS_EN: no combinational path from imem_rdata to dec_*.

Structure
REQ-036 Package pfetch_pkg SHALL hold the state enum (S_VEC, S_RUN) and the default constants for AW, IW and DEPTH.
REQ-037 The queue SHALL be one sub-module, pfetch_fifo, parametrised by width AW+IW and DEPTH, with push, pop, clear, full, empty and count.
REQ-038 The PC, the FSM and the fetch/redirect logic SHALL live in pfetch_unit.

Verification
REQ-039 Reset vector: imem[0] = 0x20, reset released -> cycle 1 imem_addr = 0x00; cycle 2 imem_addr = 0x20; first pop gives dec_pc = 0x20.
REQ-040 Fill: dec_ready = 0, 6 run cycles with DEPTH = 4 -> occupancy = 4, pc = vector+4 and held; dec_ready = 1 -> pc PCs in order vector..vector+3.
REQ-041 Redirect: occupancy = 3, redirect_valid with redirect_pc = 0x80 -> next cycle occupancy = 0 and dec_valid = 0; following pop gives dec_pc = 0x80.
REQ-042 Redirect vs stall: redirect_valid and stall_f both high -> redirect taken, pc = redirect_pc; then stall_f alone for 3 cycles -> pc unchanged, no push.
REQ-043 Wrap: AW = 8, redirect_pc = 0xFF -> dec_pc sequence 0xFF, 0x00, 0x01.
REQ-044 Bypass: PFETCH_BYPASS_EN defined, empty queue, dec_ready = 1 -> dec_valid in the same cycle as the fetch and occupancy stays 0; without the macro, dec_valid rises one cycle later.
